axis_velocity_estimator: RTL and testbench
==========================================

AXIS_VELOCITY_ESTIMATOR -- requirements
Module: axis_velocity_estimator

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, giving the width of the signed position and velocity words.
REQ-002 The block SHALL have parameter MAX_LOG2_WINDOW, default 16, giving the largest allowed window exponent.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port log2_window, input, 5 bits: window length N = 2^log2_window samples.
REQ-006 The block SHALL have port S_AXIS_tvalid, input, 1 bit: position sample valid; no tready, every valid cycle is accepted.
REQ-007 The block SHALL have port S_AXIS_tdata, input, AXIS_TDATA_WIDTH bits: signed fringe position count from the upstream position tracker.
REQ-008 The block SHALL have port M_AXIS_tvalid, output, 1 bit: velocity result valid.
REQ-009 The block SHALL have port M_AXIS_tready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port M_AXIS_tdata, output, AXIS_TDATA_WIDTH bits: signed position delta over one window.
REQ-011 The block SHALL have port M_AXIS_tuser, output, 1 bit: set when the current M_AXIS_tdata was saturated.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a result is dropped.

Function
REQ-013 The block SHALL implement a two-state FSM, PRIME and RUN, and SHALL enter PRIME on reset.
REQ-014 In PRIME, the first accepted sample SHALL be latched as the reference position; the sample counter SHALL clear, k SHALL latch min(log2_window, MAX_LOG2_WINDOW), and the FSM SHALL go to RUN; no result is produced.
REQ-015 In RUN, each accepted sample SHALL increment the counter; cycles with S_AXIS_tvalid=0 SHALL leave all state unchanged.
REQ-016 A window boundary SHALL occur on the accepted sample that makes the counter equal N=2^k, i.e. the Nth sample after the reference; k=0 gives a boundary on every sample.
REQ-017 At a boundary, delta = sample - reference SHALL be computed at AXIS_TDATA_WIDTH+1 bits, then saturated to the signed AXIS_TDATA_WIDTH range; tuser=1 iff saturation occurred.
REQ-018 At a boundary, the reference SHALL take the sample value, the counter SHALL clear, and k SHALL re-latch the clamped log2_window; log2_window changes mid-window SHALL take effect only at the next boundary.
REQ-019 The result SHALL appear on M_AXIS_tdata/tuser with M_AXIS_tvalid=1 on the cycle after the boundary sample is accepted (latency 1).
REQ-020 M_AXIS_tvalid, tdata and tuser SHALL be held stable while tvalid=1 and tready=0; the transfer completes on a cycle with tvalid=1 and tready=1, after which tvalid SHALL drop unless a new result loads.
REQ-021 On a new result: if the output register is empty, or is being transferred that same cycle, the new result SHALL load, with no overflow.
REQ-022 On a new result while an untransferred result is stalled, the new result SHALL be dropped, the old one kept, and overflow SHALL be set and held until reset.

Reset
REQ-023 Asserting areset SHALL immediately, regardless of aclk, clear M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tuser, overflow, the counter and the reference, and SHALL return the FSM to PRIME.
REQ-024 Reset mid-window or mid-stall SHALL discard all pending data; the first accepted sample after reset deasserts SHALL re-prime.

Verification
REQ-025 The bench SHALL cover: log2_window=2, samples 0,1,2,3,4 each valid, tready=1 -> one result tdata=4, tuser=0, tvalid high exactly one cycle after sample 4.
REQ-026 The bench SHALL cover: log2_window=0, samples 10,7,7 -> results -3 then 0, one per cycle.
REQ-027 The bench SHALL cover: log2_window=0, samples 0x80000000 then 0x7FFFFFFF -> tdata=0x7FFFFFFF, tuser=1; and the reverse order -> tdata=0x80000000, tuser=1.
REQ-028 The bench SHALL cover: log2_window=0, tready=0, samples 0,5,9 -> tdata stays 5, overflow=1; after tready=1, one transfer of 5, then tvalid=0.
REQ-029 The bench SHALL cover: log2_window=1, samples 0,_,3,_,6 with tvalid=0 on the gaps -> result 6 only after the 2nd valid sample past the reference.
REQ-030 The bench SHALL cover: areset asserted between aclk edges after sample 2 of a log2_window=2 window -> outputs 0 with no clock edge; next samples 100,101,102,103,104 -> result 4.

Source files
------------

// File: rtl/axis_velocity_estimator_if.sv
// axis_velocity_estimator_if
//   Groups the streaming signals of the velocity estimator.
//   The S_AXIS_* signals carry position samples into the estimator. There is no
//   S_AXIS_tready because every valid sample is accepted.
//   The M_AXIS_* signals carry velocity results out of the estimator.
//   Modports:
//     slave  - the estimator side: consumes S_AXIS_*, produces M_AXIS_*
//     master - the surrounding logic: produces S_AXIS_* and M_AXIS_tready
interface axis_velocity_estimator_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic                        S_AXIS_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
    logic                        M_AXIS_tvalid;
    logic                        M_AXIS_tready;
    logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata;
    logic                        M_AXIS_tuser;

    modport slave (
        input  S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
        output M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tuser
    );

    modport master (
        output S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
        input  M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tuser
    );
endinterface

// File: rtl/axis_velocity_estimator.sv
// axis_velocity_estimator
//   Turns a stream of signed fringe position counts into a velocity estimate:
//   the position change over a window of N = 2^k accepted samples. There is one
//   result per window. The window exponent is sampled from log2_window at
//   priming and at each window boundary, and is clamped to MAX_LOG2_WINDOW.
//   Ports:
//     aclk        - clock, rising edge
//     areset      - asynchronous reset, active high
//     log2_window - requested window exponent
//     axis        - S_AXIS_* position samples in; M_AXIS_* results out
//                   (tuser = result was saturated)
//     overflow    - sticky flag: a result was dropped because the output was stalled
//
//   state | meaning
//   PRIME | waiting for the first sample, which becomes the reference
//   RUN   | counting samples toward the next window boundary
module axis_velocity_estimator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MAX_LOG2_WINDOW  = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [4:0]                log2_window,
    axis_velocity_estimator_if.slave  axis,
    output logic                      overflow
);
    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int CW = MAX_LOG2_WINDOW + 1;   // holds N = 2^MAX_LOG2_WINDOW
    localparam logic [4:0]   MAX_K   = 5'(MAX_LOG2_WINDOW);
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {PRIME, RUN} state_t;

    state_t          state;
    logic [W-1:0]    ref_pos;
    logic [CW-1:0]   count;
    logic [4:0]      k;

    logic [4:0]      k_next;
    logic [CW-1:0]   count_inc;
    logic [CW-1:0]   window_len;
    logic            boundary;
    logic [W:0]      delta;
    logic            delta_ovf;
    logic [W-1:0]    delta_sat;
    logic            out_free;

    always_comb begin
        k_next     = (log2_window > MAX_K) ? MAX_K : log2_window;
        count_inc  = count + CW'(1);
        window_len = CW'(1) << k;
        boundary   = axis.S_AXIS_tvalid && (state == RUN) && (count_inc == window_len);
        // Sign-extend by one bit so the difference of two W-bit values cannot wrap.
        delta      = {axis.S_AXIS_tdata[W-1], axis.S_AXIS_tdata} - {ref_pos[W-1], ref_pos};
        // The result fits in W bits only if the top two bits agree.
        delta_ovf  = delta[W] ^ delta[W-1];
        delta_sat  = delta_ovf ? (delta[W] ? SAT_MIN : SAT_MAX) : delta[W-1:0];
        // The output register can take a new result if it is empty or drains this cycle.
        out_free   = !axis.M_AXIS_tvalid || axis.M_AXIS_tready;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state              <= PRIME;
            ref_pos            <= '0;
            count              <= '0;
            k                  <= '0;
            axis.M_AXIS_tvalid <= 1'b0;
            axis.M_AXIS_tdata  <= '0;
            axis.M_AXIS_tuser  <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            if (axis.M_AXIS_tvalid && axis.M_AXIS_tready)
                axis.M_AXIS_tvalid <= 1'b0;

            if (axis.S_AXIS_tvalid) begin
                case (state)
                    PRIME: begin
                        ref_pos <= axis.S_AXIS_tdata;
                        count   <= '0;
                        k       <= k_next;
                        state   <= RUN;
                    end
                    RUN: begin
                        if (boundary) begin
                            ref_pos <= axis.S_AXIS_tdata;
                            count   <= '0;
                            k       <= k_next;
                            if (out_free) begin
                                axis.M_AXIS_tvalid <= 1'b1;
                                axis.M_AXIS_tdata  <= delta_sat;
                                axis.M_AXIS_tuser  <= delta_ovf;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            count <= count_inc;
                        end
                    end
                    default: state <= PRIME;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_velocity_estimator.sv
module tb_axis_velocity_estimator;
    logic        aclk;
    logic        areset;
    logic [4:0]  log2_window;
    logic        overflow;

    int checks;
    int errors;

    axis_velocity_estimator_if #(.AXIS_TDATA_WIDTH(32)) bus ();

    axis_velocity_estimator #(
        .AXIS_TDATA_WIDTH(32),
        .MAX_LOG2_WINDOW (16)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .log2_window(log2_window),
        .axis       (bus.slave),
        .overflow   (overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit          rst;
        logic [4:0]  lw;
        bit          v;
        logic [31:0] d;
        bit          rdy;
        bit          ev;
        logic [31:0] ed;
        bit          eu;
        bit          eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, int lw, bit v, logic [31:0] d, bit rdy,
                                bit ev, logic [31:0] ed, bit eu, bit eo);
        vec_t r;
        r.rst = rst; r.lw = 5'(lw); r.v = v; r.d = d; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.eu = eu; r.eo = eo;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(bit v, logic [31:0] d);
        bus.S_AXIS_tvalid = v;
        bus.S_AXIS_tdata  = d;
        @(posedge aclk);
        @(negedge aclk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        areset = 1'b1;
        log2_window = 5'd0;
        bus.S_AXIS_tvalid = 1'b0;
        bus.S_AXIS_tdata  = '0;
        bus.M_AXIS_tready = 1'b1;

        // log2_window=2, samples 0..4: a single result of 4, one cycle after sample 4
        vecs.push_back(mk(1, 2, 1, 32'd0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 32'd1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 32'd2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 32'd3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 32'd4, 1, 1, 32'd4, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'd0, 1, 0, 0, 0, 0));
        // log2_window=0, samples 10,7,7: results -3 then 0 back to back
        vecs.push_back(mk(1, 0, 1, 32'd10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'd7,  1, 1, 32'hFFFF_FFFD, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'd7,  1, 1, 32'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'd0,  1, 0, 0, 0, 0));
        // saturation in both directions, then an ordinary delta clears tuser
        vecs.push_back(mk(1, 0, 1, 32'h8000_0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h7FFF_FFFF, 1, 1, 32'h7FFF_FFFF, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h8000_0000, 1, 1, 32'h8000_0000, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h8000_0001, 1, 1, 32'd1, 0, 0));
        // stalled output: 5 is held, 4 (9-5) is dropped, overflow sticks
        vecs.push_back(mk(1, 0, 1, 32'd0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'd5, 0, 1, 32'd5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'd9, 0, 1, 32'd5, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'd0, 0, 1, 32'd5, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 0, 0, 0, 1));
        // log2_window=1 with idle gaps: the result only follows the 2nd valid sample
        vecs.push_back(mk(1, 1, 1, 32'd0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'd0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'd3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'd0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'd6, 1, 1, 32'd6, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'd0, 1, 0, 0, 0, 0));
        // a mid-window log2_window change only applies after the next boundary
        vecs.push_back(mk(1, 1, 1, 32'd0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'd1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'd3, 1, 1, 32'd3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'd4, 1, 1, 32'd1, 0, 0));

        // reset state, still inside reset
        #7;
        chk("reset_tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        chk("reset_tdata", bus.M_AXIS_tdata, 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(negedge aclk);
        areset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                areset = 1'b1;
                #2;
                areset = 1'b0;
            end
            log2_window       = vecs[i].lw;
            bus.M_AXIS_tready = vecs[i].rdy;
            step(vecs[i].v, vecs[i].d);
            chk($sformatf("vec%0d_tvalid", i), 32'(bus.M_AXIS_tvalid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eo));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_tdata", i), bus.M_AXIS_tdata, vecs[i].ed);
                chk($sformatf("vec%0d_tuser", i), 32'(bus.M_AXIS_tuser), 32'(vecs[i].eu));
            end
        end

        // Asynchronous reset mid-window and mid-stall, then re-prime
        areset = 1'b1;
        #2;
        areset = 1'b0;
        log2_window = 5'd2;
        bus.M_AXIS_tready = 1'b0;
        for (int s = 0; s <= 10; s++) step(1'b1, 32'(s));
        chk("stall_tvalid", 32'(bus.M_AXIS_tvalid), 32'd1);
        chk("stall_tdata", bus.M_AXIS_tdata, 32'd4);
        chk("stall_overflow", 32'(overflow), 32'd1);
        bus.S_AXIS_tvalid = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        chk("async_rst_tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        chk("async_rst_tdata", bus.M_AXIS_tdata, 32'd0);
        chk("async_rst_tuser", 32'(bus.M_AXIS_tuser), 32'd0);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        #1;
        areset = 1'b0;
        bus.M_AXIS_tready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 32'(100 + s));
            chk($sformatf("reprime_%0d_tvalid", s), 32'(bus.M_AXIS_tvalid), 32'd0);
        end
        step(1'b1, 32'd104);
        chk("reprime_result_tvalid", 32'(bus.M_AXIS_tvalid), 32'd1);
        chk("reprime_result_tdata", bus.M_AXIS_tdata, 32'd4);
        chk("reprime_result_tuser", 32'(bus.M_AXIS_tuser), 32'd0);
        chk("reprime_overflow", 32'(overflow), 32'd0);
        step(1'b0, 32'd0);
        chk("reprime_drain_tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
